// File: rtl/nvm_read_arbiter_pkg.sv
// Shared types for the NVM read arbiter: FSM state encoding.
// The response struct lives in the top module because its data width is a module parameter.
package nvm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/nvm_read_arbiter_if.sv
// Requester and reader side signals of the NVM read arbiter; master = arbiter view.
// Requesters hold req/req_addr until ack; the reader sees one read_en pulse per read.
interface nvm_read_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int AW    = 8,
  parameter int DW    = 32
);

  logic [N_REQ-1:0]    req;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ-1:0]    ack;
  logic [DW-1:0]       rsp_data;
  logic                rsp_err;
  logic                rdr_read_en;
  logic [AW-1:0]       rdr_addr;
  logic                rdr_finish;
  logic [DW-1:0]       rdr_data;

  modport master (
    input  req, req_addr, rdr_finish, rdr_data,
    output ack, rsp_data, rsp_err, rdr_read_en, rdr_addr
  );

  modport slave (
    output req, req_addr, rdr_finish, rdr_data,
    input  ack, rsp_data, rsp_err, rdr_read_en, rdr_addr
  );

endinterface

// File: rtl/nvm_read_arbiter_rr_pick.sv
// Combinational rotate-priority pick: first set req bit searching ptr, ptr+1, ... mod N_REQ.
// Zero latency; no backpressure (pure function of req and ptr).
module nvm_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    idx,
  output logic             valid
);

  int j;

  // Walk from the lowest priority down so the highest-priority hit is written last.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N_REQ;
      if (req[j]) begin
        idx   = IW'(j);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nvm_read_arbiter.sv
// Round-robin share of one NVM reader; req->read_en 2 cycles, finish->ack 1 cycle, timeout error.
// Backpressure: one read outstanding; other requesters hold req until their own ack.
module nvm_read_arbiter
  import nvm_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  nvm_read_arbiter_if.master  bus,
  output logic                busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  typedef struct packed {
    logic          err;
    logic [DW-1:0] data;
  } rsp_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    ptr_q, idx_q, pick_idx;
  logic             pick_vld;
  logic [AW-1:0]    addr_q;
  logic [CW-1:0]    cnt_q;
  logic [N_REQ-1:0] ack_q;
  logic             read_en_q;
  logic             busy_q;
  rsp_t             rsp_q;
  logic             timed_out;

  nvm_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

  assign timed_out = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_vld) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (bus.rdr_finish || timed_out) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      idx_q     <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      ack_q     <= '0;
      read_en_q <= 1'b0;
      busy_q    <= 1'b0;
      rsp_q     <= '0;
    end else begin
      busy_q    <= (state_d != IDLE);
      read_en_q <= (state_q == ISSUE);
      ack_q     <= '0;

      if (state_q == IDLE && pick_vld) begin
        idx_q  <= pick_idx;
        addr_q <= bus.req_addr[pick_idx*AW +: AW];
      end

      if (state_q == WAIT && state_d == WAIT) cnt_q <= cnt_q + 1'b1;
      else                                    cnt_q <= '0;

      // A finish on the timeout cycle still counts as a good read.
      if (state_q == WAIT && state_d == RESP) begin
        ack_q      <= ONE_HOT0 << idx_q;
        rsp_q.err  <= ~bus.rdr_finish;
        rsp_q.data <= bus.rdr_finish ? bus.rdr_data : '0;
      end else if (state_q == RESP) begin
        rsp_q <= '0;
      end

      if (state_q == RESP)
        ptr_q <= (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  assign bus.ack         = ack_q;
  assign bus.rsp_data    = rsp_q.data;
  assign bus.rsp_err     = rsp_q.err;
  assign bus.rdr_read_en = read_en_q;
  assign bus.rdr_addr    = addr_q;
  assign busy            = busy_q;

endmodule
